// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host receiver: pin conditioning, 11-bit frame deserialiser and
// E0/F0 prefix folding into one registered scan-code event per key action.
module ps2_scan_receiver #(
  parameter int clk_mhz    = 50,
  parameter int timeout_us = 1000,
  parameter int filter_len = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps_clock,
  input  logic       ps_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       is_break,
  output logic       is_extended,
  output logic       frame_err
);

  localparam int         timeout_cycles = clk_mhz * timeout_us;
  localparam int         tmo_w          = $clog2(timeout_cycles + 1);
  localparam logic [3:0] filt_last      = 4'(filter_len - 1);
  localparam logic [tmo_w-1:0] tmo_limit = tmo_w'(timeout_cycles);

  localparam logic [1:0] st_idle   = 2'd0;
  localparam logic [1:0] st_data   = 2'd1;
  localparam logic [1:0] st_parity = 2'd2;
  localparam logic [1:0] st_stop   = 2'd3;

  // ---------------------------------------------------------------------------
  // Input conditioning: index 0 is the clock pin, index 1 the data pin
  // ---------------------------------------------------------------------------
  logic [1:0] pin_raw;
  logic [1:0] meta_reg;
  logic [1:0] sync_reg;
  logic       clk_sync;
  logic       data_sync;

  assign pin_raw   = {ps_data, ps_clock};
  assign clk_sync  = sync_reg[0];
  assign data_sync = sync_reg[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_reg <= 2'b11;
      sync_reg <= 2'b11;
    end else begin
      meta_reg <= pin_raw;
      sync_reg <= meta_reg;
    end
  end

  logic       filt_reg;
  logic [3:0] filt_cnt_reg;
  logic       strobe_reg;
  logic       filt_flip;

  // The filtered clock only moves after filter_len consecutive disagreeing samples
  assign filt_flip = (clk_sync != filt_reg) && (filt_cnt_reg == filt_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_reg     <= 1'b1;
      filt_cnt_reg <= 4'd0;
      strobe_reg   <= 1'b0;
    end else begin
      strobe_reg <= filt_flip && filt_reg;
      if (clk_sync == filt_reg) begin
        filt_cnt_reg <= 4'd0;
      end else if (filt_flip) begin
        filt_reg     <= ~filt_reg;
        filt_cnt_reg <= 4'd0;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM, timeout and prefix handling
  // ---------------------------------------------------------------------------
  logic [1:0]       state_reg,    state_next;
  logic [2:0]       bit_cnt_reg,  bit_cnt_next;
  logic [7:0]       shift_reg,    shift_next;
  logic             parity_reg,   parity_next;
  logic [tmo_w-1:0] tmo_reg,      tmo_next;
  logic             ext_pend_reg, ext_pend_next;
  logic             brk_pend_reg, brk_pend_next;
  logic [7:0]       code_reg,     code_next;
  logic             brk_out_reg,  brk_out_next;
  logic             ext_out_reg,  ext_out_next;
  logic             valid_reg,    valid_next;
  logic             err_reg,      err_next;
  logic             ps_bit;
  logic             frame_good;

  assign ps_bit     = data_sync;
  assign frame_good = ps_bit && (^{shift_reg, parity_reg});

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    parity_next   = parity_reg;
    ext_pend_next = ext_pend_reg;
    brk_pend_next = brk_pend_reg;
    code_next     = code_reg;
    brk_out_next  = brk_out_reg;
    ext_out_next  = ext_out_reg;
    valid_next    = 1'b0;
    err_next      = 1'b0;

    if (state_reg == st_idle || strobe_reg) begin
      tmo_next = '0;
    end else begin
      tmo_next = tmo_reg + tmo_w'(1);
    end

    if (state_reg != st_idle && tmo_reg == tmo_limit) begin
      // A stalled frame is abandoned together with any prefix it belonged to
      state_next    = st_idle;
      shift_next    = 8'h00;
      tmo_next      = '0;
      ext_pend_next = 1'b0;
      brk_pend_next = 1'b0;
      err_next      = 1'b1;
    end else if (strobe_reg) begin
      case (state_reg)
        st_idle: begin
          if (!ps_bit) begin
            state_next   = st_data;
            bit_cnt_next = 3'd0;
          end
        end
        st_data: begin
          shift_next   = {ps_bit, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            state_next = st_parity;
          end
        end
        st_parity: begin
          parity_next = ps_bit;
          state_next  = st_stop;
        end
        default: begin
          state_next = st_idle;
          if (!frame_good) begin
            err_next      = 1'b1;
            ext_pend_next = 1'b0;
            brk_pend_next = 1'b0;
          end else if (shift_reg == 8'hE0) begin
            ext_pend_next = 1'b1;
          end else if (shift_reg == 8'hF0) begin
            brk_pend_next = 1'b1;
          end else begin
            code_next     = shift_reg;
            brk_out_next  = brk_pend_reg;
            ext_out_next  = ext_pend_reg;
            valid_next    = 1'b1;
            ext_pend_next = 1'b0;
            brk_pend_next = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= st_idle;
      bit_cnt_reg  <= 3'd0;
      shift_reg    <= 8'h00;
      parity_reg   <= 1'b0;
      tmo_reg      <= '0;
      ext_pend_reg <= 1'b0;
      brk_pend_reg <= 1'b0;
      code_reg     <= 8'h00;
      brk_out_reg  <= 1'b0;
      ext_out_reg  <= 1'b0;
      valid_reg    <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      parity_reg   <= parity_next;
      tmo_reg      <= tmo_next;
      ext_pend_reg <= ext_pend_next;
      brk_pend_reg <= brk_pend_next;
      code_reg     <= code_next;
      brk_out_reg  <= brk_out_next;
      ext_out_reg  <= ext_out_next;
      valid_reg    <= valid_next;
      err_reg      <= err_next;
    end
  end

  assign code        = code_reg;
  assign code_valid  = valid_reg;
  assign is_break    = brk_out_reg;
  assign is_extended = ext_out_reg;
  assign frame_err   = err_reg;

endmodule

// File: doc/ps2_scan_receiver.md
# ps2_scan_receiver

Front-end receiver for the PS/2 keyboard path. Synchronises and de-glitches the raw `ps_clock`/`ps_data` pins, deserialises 11-bit device-to-host frames, checks start/parity/stop, and folds the 0xE0 (extended) and 0xF0 (break) prefixes into flags. It emits one registered scan-code event per key action. The scan-code-to-ASCII decoder and the seven-segment stage sit downstream and consume those events.

## Interface
Parameters:
- `clk_mhz`, 50, system clock frequency in MHz.
- `timeout_us`, 1000, maximum gap between PS/2 clock falling edges inside a frame, in µs.
- `filter_len`, 4, number of consecutive equal samples required before the filtered PS/2 clock changes; legal range 2..15.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous reset, active-low (asserted when 0).
- `ps_clock`  in  1  raw PS/2 clock pin, asynchronous.
- `ps_data`  in  1  raw PS/2 data pin, asynchronous; this block only receives and never drives it.
- `code`  out  8  last completed scan code, excluding prefixes.
- `code_valid`  out  1  single-cycle pulse; `code`/`is_break`/`is_extended` are valid in this cycle.
- `is_break`  out  1  the code was preceded by 0xF0 (key release).
- `is_extended`  out  1  the code was preceded by 0xE0.
- `frame_err`  out  1  single-cycle pulse on a bad start, parity or stop bit, or on a timeout.

## Operation
- Input conditioning:
  - Both pins pass through a 2-FF synchroniser; reset value is 1.
  - Clock filter: a counter tracks the synchronised clock. When the synchronised clock differs from the filtered clock for `filter_len` consecutive cycles, the filtered clock toggles. Any agreeing sample clears the counter. Filtered clock resets to 1.
  - Sample strobe: one cycle, generated on the filtered clock's 1→0 transition. The synchronised data value in that cycle is the bit.
- FSM (reset state IDLE):
  - IDLE: on strobe with bit=0, go to DATA with bit count 0. On strobe with bit=1, stay in IDLE with no error.
  - DATA: shift the bit into the shift register LSB-first (new bit enters [7], register shifts right). After the 8th bit, go to PARITY.
  - PARITY: store the bit; go to STOP.
  - STOP: frame is good when stop=1 and XOR(8 data bits, parity)=1 (odd parity). Good frame goes to prefix handling; bad frame pulses `frame_err`. Both go to IDLE.
- Timeout:
  - Cycle counter, width `$clog2(clk_mhz*timeout_us+1)`, cleared on every strobe and held at 0 in IDLE.
  - Outside IDLE, when the count reaches `clk_mhz*timeout_us`: pulse `frame_err`, discard the partial byte, go to IDLE.
- Prefix handling on a good byte:
  - 0xE0: set `ext_pend`; no event.
  - 0xF0: set `brk_pend`; no event.
  - Any other value, including 0x00, 0xFF and 0xE1: load `code`; set `is_break`=`brk_pend` and `is_extended`=`ext_pend`; pulse `code_valid`; clear both pending flags.
  - Any `frame_err` also clears both pending flags.
- Outputs `code`, `is_break` and `is_extended` hold their values until the next `code_valid`.
- `code_valid` and `frame_err` are never asserted in the same cycle.

## Timing
- Reset values: `code`=0x00, `code_valid`=0, `is_break`=0, `is_extended`=0, `frame_err`=0. Internally: FSM in IDLE, pending flags 0, counters 0.
- Reset asserted mid-frame aborts immediately with no event. After release, the next start bit begins a fresh frame.
- Pin-to-strobe latency: 2 (synchroniser) + `filter_len` + 1 cycles after a clean falling edge.
- `code_valid`/`frame_err` go high on the clock edge after the STOP strobe (or after the timeout match) and last exactly 1 cycle.
- Minimum PS/2 half-period is 30 µs, i.e. ≥1500 cycles at 50 MHz, so no strobes are lost. Filter pulses shorter than `filter_len` cycles are ignored.
- Back-to-back frames need no idle gap beyond the PS/2 protocol minimum.

## Test plan
- Frame 0x1C (start 0, data LSB-first, parity 0, stop 1) at 12.5 kHz → exactly one `code_valid`, `code`=0x1C, `is_break`=0, `is_extended`=0, `frame_err` never asserted.
- Frames F0,1C → one `code_valid` only (none for F0), `code`=0x1C, `is_break`=1, `is_extended`=0.
- Frames E0,F0,75 → one `code_valid`, `code`=0x75, `is_extended`=1, `is_break`=1. A following frame 0x75 → `is_extended`=0, `is_break`=0.
- Frame 0x1C with parity forced to 1 → `frame_err` pulse, no `code_valid`. Then F0 with a bad stop bit, then 0x32 → `frame_err` once, then `code`=0x32 with `is_break`=0 (pending flag cleared).
- 5 bits of a frame, then idle 1.2 ms → `frame_err` once at 1000 µs after the last edge. Next full frame 0x32 → `code`=0x32.
- Glitch checks: 3-cycle low pulses on `ps_clock` with `filter_len`=4 → no state change. Separately, `rst` low for 2 cycles mid-frame → all outputs 0, no event; the next good frame 0x1C decodes normally.
